// File: rtl/maze_position_tracker_if.sv
// Handler/renderer-facing bundle for the maze position tracker.
// slave = tracker side (samples handler controls, drives position/status); master = handler/test side.
interface maze_position_tracker_if;
  logic       move_tick;
  logic [7:0] next_count;
  logic [7:0] begin_spot;
  logic [7:0] goal_spot;
  logic       CTRLbtn;
  logic [7:0] count;
  logic [3:0] row;
  logic [4:0] col;
  logic       game_pause;
  logic [1:0] state;
  logic [1:0] lives;
  logic [9:0] steps;
  logic [9:0] best_steps;
  logic       hit_pulse;
  logic       win_pulse;

  modport master (
    output move_tick, next_count, begin_spot, goal_spot, CTRLbtn,
    input  count, row, col, game_pause, state, lives, steps, best_steps, hit_pulse, win_pulse
  );

  modport slave (
    input  move_tick, next_count, begin_spot, goal_spot, CTRLbtn,
    output count, row, col, game_pause, state, lives, steps, best_steps, hit_pulse, win_pulse
  );
endinterface

// File: rtl/maze_position_tracker.sv
// Player cell/lives/steps/best-score tracker with the play/dead/won/over FSM.
// All state updates on the CLK edge sampling move_tick; pulses last one cycle; no backpressure.
module maze_position_tracker #(
  parameter int COLS  = 18,
  parameter int CELLS = 198,
  parameter int START = 181,
  parameter int LIVES = 3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  maze_position_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    DEAD = 2'd1,
    WON  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [7:0] WALL     = 8'd255;
  localparam logic [9:0] STEP_MAX = 10'd1023;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [1:0] lives_q, lives_d;
  logic [9:0] steps_q, steps_d;
  logic [9:0] best_q, best_d;
  logic       pause_q, pause_d;
  logic       hit_q, hit_d;
  logic       win_q, win_d;
  logic [9:0] steps_inc;
  logic       nc_valid;
  logic [3:0] row_c;
  logic [4:0] col_c;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= PLAY;
      count_q <= 8'(START);
      lives_q <= 2'(LIVES);
      steps_q <= '0;
      best_q  <= STEP_MAX;
      pause_q <= 1'b1;
      hit_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lives_q <= lives_d;
      steps_q <= steps_d;
      best_q  <= best_d;
      pause_q <= pause_d;
      hit_q   <= hit_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lives_d   = lives_q;
    steps_d   = steps_q;
    best_d    = best_q;
    hit_d     = 1'b0;
    win_d     = 1'b0;
    steps_inc = (steps_q == STEP_MAX) ? STEP_MAX : steps_q + 10'd1;
    nc_valid  = (bus.next_count != WALL) && (int'(bus.next_count) < CELLS);

    if (bus.move_tick) begin
      unique case (state_q)
        PLAY: begin
          if (!nc_valid) begin
            count_d = WALL;
            hit_d   = 1'b1;
            // Last life goes straight to OVER so lives settles at zero, never wraps.
            if (lives_q <= 2'd1) begin
              lives_d = 2'd0;
              state_d = OVER;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = DEAD;
            end
          end else if (bus.next_count != count_q) begin
            count_d = bus.next_count;
            steps_d = steps_inc;
            if (bus.next_count == bus.goal_spot) begin
              state_d = WON;
              win_d   = 1'b1;
              if (steps_inc < best_q) best_d = steps_inc;
            end
          end
        end
        DEAD: begin
          if (nc_valid) begin
            count_d = bus.next_count;
            state_d = PLAY;
          end
        end
        WON, OVER: begin
          if (bus.CTRLbtn) begin
            count_d = 8'(START);
            lives_d = 2'(LIVES);
            steps_d = '0;
            state_d = PLAY;
          end
        end
        default: state_d = PLAY;
      endcase
    end

    pause_d = (state_d == PLAY) || (state_d == DEAD);
  end

  // Row/col by compare chain against multiples of COLS; the last passing compare wins.
  always_comb begin
    row_c = '0;
    col_c = '0;
    if (count_q != WALL) begin
      col_c = 5'(count_q);
      for (int r = 1; r < 16; r++) begin
        if (int'(count_q) >= r * COLS) begin
          row_c = 4'(r);
          col_c = 5'(int'(count_q) - r * COLS);
        end
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.row        = row_c;
  assign bus.col        = col_c;
  assign bus.game_pause = pause_q;
  assign bus.state      = state_q;
  assign bus.lives      = lives_q;
  assign bus.steps      = steps_q;
  assign bus.best_steps = best_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.win_pulse  = win_q;

endmodule
